// File: rtl/branch_redirect_unit_pkg.sv
// Shared definitions for the branch redirect unit: branch decision codes (same as the
// comparator), FSM state encodings and the fetch PC step.
package branch_redirect_unit_pkg;

  typedef enum logic [1:0] {
    BR_NONE  = 2'b00,
    BR_TAKEN = 2'b01,
    BR_JUMP  = 2'b10,
    BR_RSVD  = 2'b11
  } br_code_e;

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_REDIRECT = 2'b01,
    S_FLUSH    = 2'b10
  } state_e;

  localparam int PC_STEP = 2;
  localparam int CNT_W   = 3;

  // Reserved code and "no branch" both fall through as not taken.
  function automatic logic br_is_taken(input logic valid, input logic [1:0] code);
    return valid && ((code == BR_TAKEN) || (code == BR_JUMP));
  endfunction

endpackage

// File: rtl/branch_redirect_unit_target_adder.sv
// bru_target_adder: combinational branch target br_pc + 2 + br_offset, wrapping
// modulo 2^ADDR_W.
module bru_target_adder
  import branch_redirect_unit_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] br_pc,
  input  logic [ADDR_W-1:0] br_offset,
  output logic [ADDR_W-1:0] target
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  assign target = br_pc + STEP + br_offset;

endmodule

// File: rtl/branch_redirect_unit.sv
// branch_redirect_unit: owns the fetch PC, redirects on taken branches/jumps and
// sequences IF/ID + ID/EX flush bubbles. Optional BRU_STATS_EN adds outcome counters.
module branch_redirect_unit
  import branch_redirect_unit_pkg::*;
#(
  parameter int                ADDR_W       = 16,
  parameter int                FLUSH_CYCLES = 2,
  parameter logic [ADDR_W-1:0] RESET_PC     = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              br_valid,
  input  logic [1:0]        branch,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic [ADDR_W-1:0] br_offset,
  input  logic              stall,
  output logic [ADDR_W-1:0] pc,
  output logic              flush_ifid,
  output logic              flush_idex,
  output logic              redirect_busy
`ifdef BRU_STATS_EN
  ,
  output logic [15:0]       taken_cnt,
  output logic [15:0]       nottaken_cnt
`endif
);

  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(PC_STEP);
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(FLUSH_CYCLES - 1);

  state_e            state_reg, state_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [ADDR_W-1:0] target;
  logic              taken;

  bru_target_adder #(.ADDR_W(ADDR_W)) u_target_adder (
    .br_pc     (br_pc),
    .br_offset (br_offset),
    .target    (target)
  );

  assign taken = br_is_taken(br_valid, branch);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      count_reg <= '0;
      pc_reg    <= RESET_PC;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      pc_reg    <= pc_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    pc_next    = pc_reg;
    if (!stall) begin
      case (state_reg)
        S_IDLE: begin
          if (taken) begin
            pc_next    = target;
            count_next = CNT_INIT;
            state_next = S_REDIRECT;
          end else begin
            pc_next = pc_reg + STEP;
          end
        end
        S_REDIRECT: begin
          pc_next    = pc_reg + STEP;
          state_next = (count_reg == '0) ? S_IDLE : S_FLUSH;
        end
        S_FLUSH: begin
          // The count holds the bubbles still owed including this one.
          pc_next    = pc_reg + STEP;
          count_next = count_reg - 1'b1;
          if (count_next == '0) begin
            state_next = S_IDLE;
          end
        end
        default: begin
          state_next = S_IDLE;
          count_next = '0;
        end
      endcase
    end
  end

  assign pc            = pc_reg;
  assign flush_ifid    = (state_reg == S_REDIRECT) || (state_reg == S_FLUSH);
  assign flush_idex    = (state_reg == S_REDIRECT);
  assign redirect_busy = (state_reg == S_REDIRECT) || (state_reg == S_FLUSH);

`ifdef BRU_STATS_EN
  logic       accept;
  logic [1:0] stat_hit;

  // Only decisions the FSM actually acts on are counted.
  assign accept      = (state_reg == S_IDLE) && !stall && br_valid;
  assign stat_hit[0] = accept && taken;
  assign stat_hit[1] = accept && !taken;

  for (genvar gi = 0; gi < 2; gi++) begin : g_stat
    logic [15:0] cnt_reg;
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_reg <= '0;
      end else if (stat_hit[gi] && (cnt_reg != 16'hFFFF)) begin
        cnt_reg <= cnt_reg + 16'd1;
      end
    end
  end

  assign taken_cnt    = g_stat[0].cnt_reg;
  assign nottaken_cnt = g_stat[1].cnt_reg;
`endif

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Directed bench for branch_redirect_unit: each step drives inputs, queues the expected
// post-edge outputs, then pops and compares them after the clock edge.
module tb_branch_redirect_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        br_valid;
  logic [1:0]  branch;
  logic [15:0] br_pc;
  logic [15:0] br_offset;
  logic        stall;
  logic [15:0] pc;
  logic        flush_ifid;
  logic        flush_idex;
  logic        redirect_busy;
`ifdef BRU_STATS_EN
  logic [15:0] taken_cnt;
  logic [15:0] nottaken_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int step_no = 0;

  typedef struct {
    logic [15:0] pc;
    logic        fi;
    logic        fe;
    logic        busy;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  branch_redirect_unit #(
    .ADDR_W       (16),
    .FLUSH_CYCLES (2),
    .RESET_PC     (16'h0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .br_valid      (br_valid),
    .branch        (branch),
    .br_pc         (br_pc),
    .br_offset     (br_offset),
    .stall         (stall),
    .pc            (pc),
    .flush_ifid    (flush_ifid),
    .flush_idex    (flush_idex),
    .redirect_busy (redirect_busy)
`ifdef BRU_STATS_EN
    ,
    .taken_cnt     (taken_cnt),
    .nottaken_cnt  (nottaken_cnt)
`endif
  );

  task automatic step(input string tag, input logic r, input logic bv, input logic [1:0] br,
                      input logic [15:0] bpc, input logic [15:0] off, input logic st,
                      input logic [15:0] e_pc, input logic e_fi, input logic e_fe,
                      input logic e_busy);
    exp_t e;
    exp_t got;
    @(negedge clk);
    rst       = r;
    br_valid  = bv;
    branch    = br;
    br_pc     = bpc;
    br_offset = off;
    stall     = st;
    e.pc = e_pc; e.fi = e_fi; e.fe = e_fe; e.busy = e_busy;
    sb.push_back(e);
    @(posedge clk);
    #1;
    step_no++;
    got = sb.pop_front();
    checks++;
    assert (pc === got.pc) else begin
      errors++;
      $error("FAIL %s step %0d pc got %h exp %h", tag, step_no, pc, got.pc);
    end
    checks++;
    assert (flush_ifid === got.fi) else begin
      errors++;
      $error("FAIL %s step %0d flush_ifid got %b exp %b", tag, step_no, flush_ifid, got.fi);
    end
    checks++;
    assert (flush_idex === got.fe) else begin
      errors++;
      $error("FAIL %s step %0d flush_idex got %b exp %b", tag, step_no, flush_idex, got.fe);
    end
    checks++;
    assert (redirect_busy === got.busy) else begin
      errors++;
      $error("FAIL %s step %0d busy got %b exp %b", tag, step_no, redirect_busy, got.busy);
    end
    $display("step %0d %s: pc=%h fi=%b fe=%b busy=%b", step_no, tag, pc, flush_ifid,
             flush_idex, redirect_busy);
  endtask

  initial begin
    rst = 1'b1; br_valid = 1'b0; branch = 2'b00; br_pc = '0; br_offset = '0; stall = 1'b0;
    //    tag          rst  bv   br     br_pc     offset    stall  pc        fi   fe   busy
    step("reset",      1'b1, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    step("free1",      1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
    step("free2",      1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0004, 1'b0, 1'b0, 1'b0);
    step("free3",      1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0006, 1'b0, 1'b0, 1'b0);
    step("free4",      1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0008, 1'b0, 1'b0, 1'b0);
    step("taken",      1'b0, 1'b1, 2'b01, 16'h0010, 16'h0004, 1'b0, 16'h0016, 1'b1, 1'b1, 1'b1);
    step("redir_ign",  1'b0, 1'b1, 2'b10, 16'h0100, 16'h0040, 1'b0, 16'h0018, 1'b1, 1'b0, 1'b1);
    step("flush_end",  1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 16'h001A, 1'b0, 1'b0, 1'b0);
    step("rsvd",       1'b0, 1'b1, 2'b11, 16'h0010, 16'h0004, 1'b0, 16'h001C, 1'b0, 1'b0, 1'b0);
    step("none",       1'b0, 1'b1, 2'b00, 16'h0010, 16'h0004, 1'b0, 16'h001E, 1'b0, 1'b0, 1'b0);
    step("novalid",    1'b0, 1'b0, 2'b01, 16'h0010, 16'h0004, 1'b0, 16'h0020, 1'b0, 1'b0, 1'b0);
    step("jump_wrap",  1'b0, 1'b1, 2'b10, 16'hFFFC, 16'h0004, 1'b0, 16'h0002, 1'b1, 1'b1, 1'b1);
    step("wrap_fl",    1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0004, 1'b1, 1'b0, 1'b1);
    step("wrap_idle",  1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0006, 1'b0, 1'b0, 1'b0);
    step("neg_off",    1'b0, 1'b1, 2'b10, 16'h0020, 16'hFFF8, 1'b0, 16'h001A, 1'b1, 1'b1, 1'b1);
    step("neg_fl",     1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 16'h001C, 1'b1, 1'b0, 1'b1);
    step("stall_fl1",  1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b1, 16'h001C, 1'b1, 1'b0, 1'b1);
    step("stall_fl2",  1'b0, 1'b1, 2'b01, 16'h0000, 16'h0010, 1'b1, 16'h001C, 1'b1, 1'b0, 1'b1);
    step("stall_fl3",  1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b1, 16'h001C, 1'b1, 1'b0, 1'b1);
    step("release",    1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 16'h001E, 1'b0, 1'b0, 1'b0);
    step("stall_br",   1'b0, 1'b1, 2'b01, 16'h0100, 16'h0000, 1'b1, 16'h001E, 1'b0, 1'b0, 1'b0);
    step("resample",   1'b0, 1'b1, 2'b01, 16'h0100, 16'h0000, 1'b0, 16'h0102, 1'b1, 1'b1, 1'b1);
    step("rst_redir",  1'b1, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    step("post_rst",   1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
    step("to_fffe",    1'b0, 1'b1, 2'b10, 16'hFFF0, 16'h000C, 1'b0, 16'hFFFE, 1'b1, 1'b1, 1'b1);
    step("pc_wrap",    1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    step("after_wrap", 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
